// File: rtl/adder_seq_ctrl.sv
// Wide adder built from one shared external 4-bit adder slice, used one nibble per cycle, LSB nibble first.
// Optional build macro ADD_SUB_EN adds a 'sub' input that makes the result A - B.
module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   ready,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_co
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic          cout_reg;
  logic [IW-1:0] idx_reg;

  logic [3:0]    a_sel;
  logic [3:0]    b_sel;
  logic          carry_init;

  assign a_sel = a_reg[{idx_reg, 2'b00} +: 4];

`ifdef ADD_SUB_EN
  logic sub_reg;

  // Subtraction is A + ~B + 1, so the first carry is forced high.
  assign b_sel      = sub_reg ? ~b_reg[{idx_reg, 2'b00} +: 4] : b_reg[{idx_reg, 2'b00} +: 4];
  assign carry_init = sub ? 1'b1 : cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      sub_reg <= sub;
    end
  end
`else
  assign b_sel      = b_reg[{idx_reg, 2'b00} +: 4];
  assign carry_init = cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= carry_init;
            idx_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          carry_reg <= add_co;
          // idx stops at the last nibble rather than wrapping.
          if (idx_reg == IW'(NIBBLES - 1)) begin
            cout_reg  <= add_co;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Each result nibble owns a register that loads only on its own BUSY cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi = gi + 1) begin : g_nib
      logic [3:0] nib_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          nib_reg <= 4'h0;
        end else if (state_reg == BUSY && idx_reg == IW'(gi)) begin
          nib_reg <= add_sum;
        end
      end

      assign sum[4*gi +: 4] = nib_reg;
    end
  endgenerate

  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_reg == BUSY) begin
      add_a   = a_sel;
      add_b   = b_sel;
      add_cin = carry_reg;
    end
  end

  assign ready = (state_reg == IDLE);
  assign done  = (state_reg == DONE);
  assign cout  = cout_reg;

endmodule
